// File: rtl/uart_rx_pkg.sv
// Shared UART constants used by both directions of the serial link.
package uart_rx_pkg;

  localparam int unsigned CNT_W              = 9;
  localparam logic [CNT_W-1:0] UART_CLOCK_DEFAULT = 9'd434;
  localparam int unsigned FRAME_BITS         = 8;

  // Count value at which the half-bit (start bit centre) has elapsed.
  function automatic logic [CNT_W-1:0] half_bit_last(input logic [CNT_W-1:0] period);
    return (period >> 1) - 9'd1;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line and ack in, received byte and status out.
interface uart_rx_if;
  import uart_rx_pkg::*;

  logic                  rx;
  logic                  ack;
  logic [FRAME_BITS-1:0] rx_data;
  logic                  valid;
  logic                  frame_err;
  logic                  overrun;

  modport master (
    output rx,
    output ack,
    input  rx_data,
    input  valid,
    input  frame_err,
    input  overrun
  );

  modport slave (
    input  rx,
    input  ack,
    output rx_data,
    output valid,
    output frame_err,
    output overrun
  );

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for the asynchronous serial line; idles high out of reset.
module uart_sync_2ff (
  input  logic clock_50M,
  input  logic n_rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock_50M) begin
    if (!n_rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, framing check, single-entry holding register.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter logic [CNT_W-1:0] UART_CLOCK = UART_CLOCK_DEFAULT
) (
  input logic     clock_50M,
  input logic     n_rst,
  uart_rx_if.slave bus
);

  if (UART_CLOCK < 9'd4) begin : g_bad_clock
    $error("uart_rx: UART_CLOCK must be at least 4");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  localparam logic [CNT_W-1:0] HALF_LAST = half_bit_last(UART_CLOCK);
  localparam logic [CNT_W-1:0] FULL_LAST = UART_CLOCK - 9'd1;
  localparam logic [2:0]       LAST_BIT  = 3'(FRAME_BITS - 1);

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [2:0]            bit_idx;
  logic [FRAME_BITS-1:0] shift;
  logic                  rx_s;
  logic                  rx_d;
  logic [1:0]            primed;
  logic [FRAME_BITS-1:0] rx_data_r;
  logic                  valid_r;
  logic                  frame_err_r;
  logic                  overrun_r;

  uart_sync_2ff u_sync (
    .clock_50M (clock_50M),
    .n_rst     (n_rst),
    .d         (bus.rx),
    .q         (rx_s)
  );

  // The synchronizer comes out of reset reporting idle-high for two cycles even
  // if the line is really low; rx_d is held low until it reflects the real line,
  // so a line low through reset never looks like a falling edge.
  always_ff @(posedge clock_50M) begin
    if (!n_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      rx_d        <= 1'b0;
      primed      <= '0;
      rx_data_r   <= '0;
      valid_r     <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      primed      <= {primed[0], 1'b1};
      rx_d        <= primed[1] & rx_s;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;

      if (bus.ack && valid_r) begin
        valid_r <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!rx_s && rx_d) begin
            state <= START;
            cnt   <= '0;
          end
        end

        START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 9'd1;
          end
        end

        DATA: begin
          if (cnt == FULL_LAST) begin
            cnt   <= '0;
            shift <= {rx_s, shift[FRAME_BITS-1:1]};
            if (bit_idx == LAST_BIT) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 9'd1;
          end
        end

        // Leaving at mid stop bit leaves half a bit to catch a back-to-back start.
        STOP: begin
          if (cnt == FULL_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              rx_data_r <= shift;
              valid_r   <= 1'b1;
              overrun_r <= valid_r && !bus.ack;
              state     <= IDLE;
            end else begin
              frame_err_r <= 1'b1;
              state       <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 9'd1;
          end
        end

        WAIT_HIGH: begin
          if (rx_s) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rx_data   = rx_data_r;
  assign bus.valid     = valid_r;
  assign bus.frame_err = frame_err_r;
  assign bus.overrun   = overrun_r;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: framed bytes, glitches, framing errors, overrun, reset.
module tb_uart_rx;
  import uart_rx_pkg::*;

  localparam int          CLK_HALF = 10;
  localparam int          C        = 434;
  localparam int          LAT_NOM  = 2 + C / 2 + 9 * C + 1;

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    logic       ack_after;
    logic [7:0] exp_data;
    logic       exp_valid;
    int         exp_fe;
    int         exp_ovr;
  } vec_t;

  logic clk;
  logic n_rst;
  int   checks = 0;
  int   errors = 0;
  int   fe_cnt = 0;
  int   ovr_cnt = 0;
  int   long_pulses = 0;
  logic fe_prev = 1'b0;
  logic ovr_prev = 1'b0;

  uart_rx_if bus_if ();

  uart_rx #(.UART_CLOCK(9'(C))) dut (
    .clock_50M (clk),
    .n_rst     (n_rst),
    .bus       (bus_if)
  );

  initial clk = 1'b0;
  always #(CLK_HALF) clk = ~clk;

  // Pulse counters; a status output high on two consecutive samples is a width error.
  always @(negedge clk) begin
    if (bus_if.frame_err === 1'b1) fe_cnt++;
    if (bus_if.overrun === 1'b1) ovr_cnt++;
    if (fe_prev && bus_if.frame_err === 1'b1) long_pulses++;
    if (ovr_prev && bus_if.overrun === 1'b1) long_pulses++;
    fe_prev  = (bus_if.frame_err === 1'b1);
    ovr_prev = (bus_if.overrun === 1'b1);
  end

  initial begin
    #(CLK_HALF * 2 * 200000);
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drives one 8N1 frame starting at a falling clock edge; returns after 10 bit times.
  task automatic apply_stimulus(input logic [7:0] data, input logic stop_bit);
    bus_if.rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus_if.rx = data[i];
      repeat (C) @(negedge clk);
    end
    bus_if.rx = stop_bit;
    repeat (C) @(negedge clk);
    bus_if.rx = 1'b1;
  endtask

  task automatic pulse_ack();
    bus_if.ack = 1'b1;
    @(negedge clk);
    bus_if.ack = 1'b0;
  endtask

  vec_t vec [5];
  int   fe0;
  int   ov0;
  int   lat;

  initial begin
    vec[0] = '{8'h3C, 1'b0, 1'b0, 8'hA5, 1'b0, 1, 0};
    vec[1] = '{8'h5A, 1'b1, 1'b0, 8'h5A, 1'b1, 0, 0};
    vec[2] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 0, 1};
    vec[3] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 0, 1};
    vec[4] = '{8'hC3, 1'b1, 1'b1, 8'hC3, 1'b1, 0, 0};

    n_rst     = 1'b0;
    bus_if.rx  = 1'b1;
    bus_if.ack = 1'b0;
    repeat (5) @(negedge clk);
    check_output("reset rx_data", 32'(bus_if.rx_data), 32'h00);
    check_output("reset valid", 32'(bus_if.valid), 32'h0);
    check_output("reset frame_err", 32'(bus_if.frame_err), 32'h0);
    check_output("reset overrun", 32'(bus_if.overrun), 32'h0);
    n_rst = 1'b1;
    repeat (10) @(negedge clk);

    $display("[TB] latency with 0xA5");
    lat = 0;
    fork
      apply_stimulus(8'hA5, 1'b1);
      begin
        for (int i = 1; i <= LAT_NOM + 200; i++) begin
          @(negedge clk);
          if (bus_if.valid === 1'b1) begin
            lat = i;
            break;
          end
        end
      end
    join
    checks++;
    if (lat < LAT_NOM - 1 || lat > LAT_NOM + 1) begin
      errors++;
      $display("[TB] FAIL latency: got %0d cycles, expected %0d +/-1", lat, LAT_NOM);
    end
    check_output("A5 rx_data", 32'(bus_if.rx_data), 32'hA5);
    check_output("A5 valid", 32'(bus_if.valid), 32'h1);
    pulse_ack();
    check_output("A5 valid after ack", 32'(bus_if.valid), 32'h0);
    repeat (20) @(negedge clk);

    $display("[TB] start glitch");
    fe0 = fe_cnt;
    bus_if.rx = 1'b0;
    repeat (100) @(negedge clk);
    bus_if.rx = 1'b1;
    repeat (500) @(negedge clk);
    check_output("glitch valid", 32'(bus_if.valid), 32'h0);
    check_output("glitch frame_err count", 32'(fe_cnt - fe0), 32'h0);
    check_output("glitch rx_data", 32'(bus_if.rx_data), 32'hA5);

    $display("[TB] vector table");
    for (int i = 0; i < 5; i++) begin
      fe0 = fe_cnt;
      ov0 = ovr_cnt;
      apply_stimulus(vec[i].data, vec[i].stop_bit);
      check_output($sformatf("vec%0d rx_data", i), 32'(bus_if.rx_data), 32'(vec[i].exp_data));
      check_output($sformatf("vec%0d valid", i), 32'(bus_if.valid), 32'(vec[i].exp_valid));
      check_output($sformatf("vec%0d frame_err count", i), 32'(fe_cnt - fe0), 32'(vec[i].exp_fe));
      check_output($sformatf("vec%0d overrun count", i), 32'(ovr_cnt - ov0), 32'(vec[i].exp_ovr));
      if (vec[i].ack_after) begin
        pulse_ack();
        check_output($sformatf("vec%0d valid after ack", i), 32'(bus_if.valid), 32'h0);
      end
      repeat (20) @(negedge clk);
    end

    $display("[TB] back-to-back without ack");
    ov0 = ovr_cnt;
    apply_stimulus(8'h11, 1'b1);
    apply_stimulus(8'h22, 1'b1);
    check_output("b2b overrun count", 32'(ovr_cnt - ov0), 32'h1);
    check_output("b2b rx_data", 32'(bus_if.rx_data), 32'h22);
    check_output("b2b valid", 32'(bus_if.valid), 32'h1);
    pulse_ack();
    repeat (20) @(negedge clk);

    $display("[TB] back-to-back with ack on load cycle");
    ov0 = ovr_cnt;
    apply_stimulus(8'h11, 1'b1);
    fork
      apply_stimulus(8'h22, 1'b1);
      begin
        repeat (LAT_NOM - 1) @(negedge clk);
        bus_if.ack = 1'b1;
        @(negedge clk);
        bus_if.ack = 1'b0;
      end
    join
    check_output("b2b-ack overrun count", 32'(ovr_cnt - ov0), 32'h0);
    check_output("b2b-ack rx_data", 32'(bus_if.rx_data), 32'h22);
    check_output("b2b-ack valid", 32'(bus_if.valid), 32'h1);
    repeat (20) @(negedge clk);

    $display("[TB] reset mid-frame with line low");
    fe0 = fe_cnt;
    ov0 = ovr_cnt;
    bus_if.rx = 1'b0;
    repeat (1000) @(negedge clk);
    n_rst = 1'b0;
    repeat (5) @(negedge clk);
    check_output("midreset rx_data", 32'(bus_if.rx_data), 32'h00);
    check_output("midreset valid", 32'(bus_if.valid), 32'h0);
    n_rst = 1'b1;
    repeat (2000) @(negedge clk);
    bus_if.rx = 1'b1;
    repeat (3000) @(negedge clk);
    check_output("post-reset valid", 32'(bus_if.valid), 32'h0);
    check_output("post-reset rx_data", 32'(bus_if.rx_data), 32'h00);
    check_output("post-reset frame_err count", 32'(fe_cnt - fe0), 32'h0);
    check_output("post-reset overrun count", 32'(ovr_cnt - ov0), 32'h0);
    apply_stimulus(8'h77, 1'b1);
    check_output("0x77 rx_data", 32'(bus_if.rx_data), 32'h77);
    check_output("0x77 valid", 32'(bus_if.valid), 32'h1);
    repeat (20) @(negedge clk);

    check_output("pulse widths", 32'(long_pulses), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
